scoreboard_register_file: RTL
=============================

// Module: scoreboard_register_file
// PURPOSE
// - Parametrised general-purpose register file for the pipelined MIPS core.
// - 2 async read ports, 1 sync write port; register 0 hardwired to zero.
// - Per-register pending-write scoreboard: decode marks a destination busy at
//   issue, writeback clears it. Hazard logic stalls on the busy flags.
// PARAMETERS
// - DATA_W     32  register width in bits
// - ADDR_W     5   register address width; depth = 2**ADDR_W
// - PENDING_W  2   per-register pending-write counter width; max in flight = 2**PENDING_W-1
// PORTS
// - clock          in   1        rising-edge clock, sole clock domain
// - reset          in   1        synchronous, active-high
// - readRegister1  in   ADDR_W   read port 1 address
// - readRegister2  in   ADDR_W   read port 2 address
// - readData1      out  DATA_W   read port 1 data
// - readData2      out  DATA_W   read port 2 data
// - busy1          out  1        readRegister1 has a pending write
// - busy2          out  1        readRegister2 has a pending write
// - regWrite       in   1        writeback strobe
// - writeRegister  in   ADDR_W   writeback address
// - writeData      in   DATA_W   writeback data
// - issueValid     in   1        decode issues an instruction that writes issueRegister
// - issueRegister  in   ADDR_W   destination being issued
// - issueReady     out  1        issue is accepted this cycle
// BEHAVIOUR
// - Reset (clock edge with reset=1): all registers <- 0, all counters <- 0.
//   Resulting outputs: readData*=0, busy*=0, issueReady=1. Reset overrides
//   regWrite/issueValid in the same cycle. Reset mid-flight discards all
//   pending state; writebacks that arrive later update data only.
// - Read: combinational, 0-cycle latency. Address 0 always reads 0.
// - Write: on a rising edge with regWrite=1 and writeRegister!=0,
//   registers[writeRegister] <- writeData. Writes to register 0 are dropped.
// - Scoreboard: cnt[r] is PENDING_W bits wide; cnt[0] is constant 0.
//   inc = issueValid & issueReady & issueRegister!=0
//   dec = regWrite & writeRegister!=0 & cnt[writeRegister]!=0
//   Same register with inc and dec in one cycle: cnt is unchanged.
//   Different registers: both updates apply.
//   A writeback to a register with cnt=0 (no issue) writes data only; cnt
//   stays 0, with no underflow.
// - issueReady = !(issueRegister!=0 & cnt[issueRegister]==max & !dec_same),
//   where dec_same = dec & writeRegister==issueRegister. This is the saturation
//   stall. issueReady is combinational and independent of issueValid.
// - busyN = cnt[readRegisterN]!=0 (see CONFIGURATION for the bypass case).
// - Simultaneous read and write to the same address: base behaviour is that
//   the read returns the old value. The new value is visible the next cycle.
// CONFIGURATION
// - Macro SCOREBOARD_RF_WRITE_BYPASS_EN:
//   * Defined: when regWrite & writeRegister==readRegisterN & writeRegister!=0,
//     readDataN = writeData in the same cycle. busyN = (cnt - dec_matchN)!=0,
//     so the final pending writeback clears busy in its own cycle.
//   * Undefined: no forwarding. readDataN returns the stored value, and busyN
//     uses cnt only, so it deasserts one cycle after the writeback.
// TESTING
// - Reset, then read all addresses -> readData1/2=0, busy1/2=0, issueReady=1.
// - Write r17=20 with regWrite=1. Next cycle read r17 -> 20. Write r0=0xDEAD,
//   then read r0 -> 0.
// - Issue r5, then read r5 -> busy1=1. Writeback r5=7 -> bypass build: same
//   cycle readData1=7, busy1=0. Non-bypass build: next cycle readData1=7,
//   busy1=0.
// - PENDING_W=2: issue r9 three times, then cnt=3. A 4th issue without
//   writeback -> issueReady=0 and cnt stays 3. Same cycle as a writeback to
//   r9 -> issueReady=1 and cnt stays 3.
// - Issue r4 and writeback r4 in the same cycle with cnt=1 -> cnt stays 1 and
//   busy stays 1. Writeback r6 with cnt=0 -> data written, cnt stays 0.
// - Issue r8 twice, assert reset, then writeback r8=3 -> busy=0, cnt=0,
//   readData(r8)=3.

Source files
------------

// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file: MIPS GPR file with two async reads, one sync write and per-register
// pending-write counters for hazard stalls. Optional macro: SCOREBOARD_RF_WRITE_BYPASS_EN.
module scoreboard_register_file #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int PENDING_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readRegister1,
  input  logic [ADDR_W-1:0] readRegister2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              busy1,
  output logic              busy2,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeRegister,
  input  logic [DATA_W-1:0] writeData,
  input  logic              issueValid,
  input  logic [ADDR_W-1:0] issueRegister,
  output logic              issueReady
);

  localparam int                   DEPTH    = 2 ** ADDR_W;
  localparam logic [PENDING_W-1:0] CNT_MAX  = '1;
  localparam logic [PENDING_W-1:0] CNT_ONE  = {{(PENDING_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]    ZERO_REG = '0;

  logic [DATA_W-1:0]    registers [DEPTH];
  logic [PENDING_W-1:0] cnt       [DEPTH];

  logic writeEn;
  logic incEn;
  logic decEn;
  logic decSame;

  // A writeback retiring the last slot of a saturated register frees room for this issue.
  always_comb begin
    writeEn    = regWrite && (writeRegister != ZERO_REG);
    decEn      = writeEn && (cnt[writeRegister] != '0);
    decSame    = decEn && (writeRegister == issueRegister);
    issueReady = !((issueRegister != ZERO_REG) && (cnt[issueRegister] == CNT_MAX) && !decSame);
    incEn      = issueValid && issueReady && (issueRegister != ZERO_REG);
  end

  function automatic logic [DATA_W-1:0] readValue(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = (addr == ZERO_REG) ? '0 : registers[addr];
`ifdef SCOREBOARD_RF_WRITE_BYPASS_EN
    if (writeEn && (writeRegister == addr)) value = writeData;
`endif
    return value;
  endfunction

  function automatic logic pendingAt(input logic [ADDR_W-1:0] addr);
    logic [PENDING_W-1:0] level;
    level = cnt[addr];
`ifdef SCOREBOARD_RF_WRITE_BYPASS_EN
    // decEn already guarantees level != 0, so this cannot wrap.
    if (decEn && (writeRegister == addr)) level = level - CNT_ONE;
`endif
    return level != '0;
  endfunction

  // NOTE: every output is assigned on every pass through always_comb, so no latch is inferred.
  always_comb begin
    readData1 = readValue(readRegister1);
    readData2 = readValue(readRegister2);
    busy1     = pendingAt(readRegister1);
    busy2     = pendingAt(readRegister2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the array is reset on purpose (architectural zero state); storage without
      // such a requirement should stay unreset so it can map onto plain RAM.
      for (int i = 0; i < DEPTH; i++) begin
        registers[i] <= '0;
        cnt[i]       <= '0;
      end
    end else begin
      // NOTE: non-blocking updates here, so the reads of cnt below all see the pre-edge value.
      if (writeEn) registers[writeRegister] <= writeData;
      // Issue and retire on the same register cancel out; register 0 never reaches here.
      if (!(incEn && decSame)) begin
        if (incEn) cnt[issueRegister] <= cnt[issueRegister] + CNT_ONE;
        if (decEn) cnt[writeRegister] <= cnt[writeRegister] - CNT_ONE;
      end
    end
  end

endmodule
